// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encoding, default width and iteration count.
package mult_div_pkg;

    localparam int DATA_W_DEF = 32;

    function automatic int iter_count(input int width);
        return width;
    endfunction

    localparam int ITERATIONS = iter_count(DATA_W_DEF);

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit (master) and the
// multiply/divide unit (slave).
interface mult_div_unit_if #(
    parameter int DATA_W = mult_div_pkg::DATA_W_DEF
);
    logic              start;
    logic              op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              busy;
    logic              done;
    logic              div_zero;

    modport master (
        output start, op, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift the next
// dividend bit into the partial remainder and subtract the divisor if it fits.
module div_step
    import mult_div_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] quo_i,
    input  logic [DATA_W-1:0] den_i,
    output logic [DATA_W:0]   rem_o,
    output logic [DATA_W-1:0] quo_o
);
    logic [DATA_W:0]   shifted;
    logic [DATA_W+1:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[DATA_W-1]};
        diff    = {1'b0, shifted} - {2'b00, den_i};
        if (!diff[DATA_W+1]) begin
            rem_o = diff[DATA_W:0];
            quo_o = {quo_i[DATA_W-2:0], 1'b1};
        end else begin
            rem_o = shifted;
            quo_o = {quo_i[DATA_W-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit with HI/LO
// result registers. The divider is built only when MULT_DIV_UNIT_DIVIDE_EN is defined.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic            clock,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);
    localparam int ITERS = iter_count(DATA_W);
    localparam int CNT_W = $clog2(ITERS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

    state_e                    state_r;
    op_e                       op_r;
    logic signed [DATA_W:0]    acc_r;
    logic [DATA_W-1:0]         q_r;
    logic                      q_m1_r;
    logic signed [DATA_W-1:0]  m_r;
    logic [CNT_W-1:0]          cnt_r;
    logic                      short_r;
    logic [DATA_W-1:0]         hi_r;
    logic [DATA_W-1:0]         lo_r;
    logic                      busy_r;
    logic                      done_r;
    logic                      dz_r;

    // Booth step: the accumulator carries one guard bit so +/- the most
    // negative multiplicand cannot overflow before the arithmetic shift.
    logic signed [DATA_W:0]    m_ext;
    logic signed [DATA_W:0]    booth_sum;
    logic signed [DATA_W:0]    acc_nxt;
    logic [DATA_W-1:0]         q_nxt;
    logic                      q_m1_nxt;

    always_comb begin
        m_ext = {m_r[DATA_W-1], m_r};
        unique case ({q_r[0], q_m1_r})
            2'b01:   booth_sum = acc_r + m_ext;
            2'b10:   booth_sum = acc_r - m_ext;
            default: booth_sum = acc_r;
        endcase
        acc_nxt  = booth_sum >>> 1;
        q_nxt    = {booth_sum[0], q_r[DATA_W-1:1]};
        q_m1_nxt = q_r[0];
    end

`ifdef MULT_DIV_UNIT_DIVIDE_EN
    logic                      neg_q_r;
    logic                      neg_r_r;
    logic [DATA_W:0]           rem_nxt;
    logic [DATA_W-1:0]         quo_nxt;

    div_step #(.DATA_W(DATA_W)) u_div_step (
        .rem_i (acc_r[DATA_W-1:0]),
        .quo_i (q_r),
        .den_i (m_r),
        .rem_o (rem_nxt),
        .quo_o (quo_nxt)
    );

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? -v : v;
    endfunction
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            op_r    <= OP_MULT;
            acc_r   <= '0;
            q_r     <= '0;
            q_m1_r  <= 1'b0;
            m_r     <= '0;
            cnt_r   <= '0;
            short_r <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dz_r    <= 1'b0;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        op_r    <= op_e'(bus.op);
                        acc_r   <= '0;
                        q_m1_r  <= 1'b0;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= CALC;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
                        if (bus.op == OP_DIV) begin
                            q_r     <= magnitude(bus.a);
                            m_r     <= magnitude(bus.b);
                            short_r <= (bus.b == '0);
                            neg_q_r <= bus.a[DATA_W-1] ^ bus.b[DATA_W-1];
                            neg_r_r <= bus.a[DATA_W-1];
                        end else begin
                            q_r     <= bus.b;
                            m_r     <= bus.a;
                            short_r <= 1'b0;
                        end
`else
                        q_r     <= bus.b;
                        m_r     <= bus.a;
                        short_r <= (bus.op == OP_DIV);
`endif
                    end
                end
                CALC: begin
                    // A short request (divide by zero, or DIV with no divider)
                    // turns around after one cycle and leaves HI/LO untouched.
                    if (short_r) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
                        dz_r    <= 1'b1;
`endif
                    end else if (cnt_r == LAST) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
                        if (op_r == OP_DIV) begin
                            lo_r <= neg_q_r ? -quo_nxt : quo_nxt;
                            hi_r <= neg_r_r ? -rem_nxt[DATA_W-1:0] : rem_nxt[DATA_W-1:0];
                        end else
`endif
                        begin
                            hi_r <= acc_nxt[DATA_W-1:0];
                            lo_r <= q_nxt;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
`ifdef MULT_DIV_UNIT_DIVIDE_EN
                        if (op_r == OP_DIV) begin
                            acc_r <= rem_nxt;
                            q_r   <= quo_nxt;
                        end else
`endif
                        begin
                            acc_r  <= acc_nxt;
                            q_r    <= q_nxt;
                            q_m1_r <= q_m1_nxt;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.div_zero = dz_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// MULT/DIV traffic against a 64-bit arithmetic reference model.
module tb_mult_div_unit;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    mult_div_unit_if #(.DATA_W(32)) bus ();

    mult_div_unit #(.DATA_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: HI/LO straight from 64-bit signed arithmetic.
    task automatic model(input bit op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output bit dz);
        longint sa, sb, p, q, r;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        dz = 1'b0;
        if (!op) begin
            p   = sa * sb;
            mhi = p[63:32];
            mlo = p[31:0];
            lat = 32;
        end else begin
`ifdef MULT_DIV_UNIT_DIVIDE_EN
            if (b == 32'd0) begin
                lat = 1;
                dz  = 1'b1;
            end else begin
                q   = sa / sb;
                r   = sa % sb;
                mlo = q[31:0];
                mhi = r[31:0];
                lat = 32;
            end
`else
            lat = 1;
`endif
        end
    endtask

    task automatic do_op(input string tag, input bit op, input logic [31:0] a,
                         input logic [31:0] b, input int poke_k);
        logic [31:0] old_hi, old_lo;
        int exp_lat, lat, busy_cnt, done_cnt, stray_dz, unstable;
        bit exp_dz, dz_at_done;
        old_hi = mhi;
        old_lo = mlo;
        model(op, a, b, exp_lat, exp_dz);
        lat = -1; busy_cnt = 0; done_cnt = 0; stray_dz = 0; unstable = 0; dz_at_done = 1'b0;
        @(negedge clock);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clock);
        bus.start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    lat = k;
                    dz_at_done = bus.div_zero;
                end
            end
            if (bus.div_zero && !bus.done) stray_dz++;
            if (done_cnt == 0 && (bus.hi !== old_hi || bus.lo !== old_lo)) unstable++;
            if (k == poke_k) begin
                bus.start = 1'b1; bus.op = $urandom_range(0, 1);
                bus.a = $urandom; bus.b = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            if (!bus.busy) break;
            @(negedge clock);
        end
        bus.start = 1'b0;
        chk({tag, "_lat"},      64'(lat),        64'(exp_lat));
        chk({tag, "_busy"},     64'(busy_cnt),   64'(exp_lat + 1));
        chk({tag, "_ndone"},    64'(done_cnt),   64'd1);
        chk({tag, "_dz"},       64'(dz_at_done), 64'(exp_dz));
        chk({tag, "_straydz"},  64'(stray_dz),   64'd0);
        chk({tag, "_stable"},   64'(unstable),   64'd0);
        chk({tag, "_hi"},       64'(bus.hi),     64'(mhi));
        chk({tag, "_lo"},       64'(bus.lo),     64'(mlo));
    endtask

    initial begin
        int done_seen;
        bit rop;
        logic [31:0] ra, rb;

        bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clock);
        chk("rst_hi",   64'(bus.hi),       64'd0);
        chk("rst_lo",   64'(bus.lo),       64'd0);
        chk("rst_busy", 64'(bus.busy),     64'd0);
        chk("rst_done", 64'(bus.done),     64'd0);
        chk("rst_dz",   64'(bus.div_zero), 64'd0);
        reset = 1'b0;

        do_op("m7", 1'b0, 32'd7, 32'hFFFFFFFD, -1);
        chk("m7_hi_c", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
        chk("m7_lo_c", 64'(bus.lo), 64'h0000_0000_FFFF_FFEB);

        do_op("mmin", 1'b0, 32'h80000000, 32'h80000000, -1);
        chk("mmin_hi_c", 64'(bus.hi), 64'h0000_0000_4000_0000);
        chk("mmin_lo_c", 64'(bus.lo), 64'd0);

`ifdef MULT_DIV_UNIT_DIVIDE_EN
        do_op("d7", 1'b1, 32'd7, 32'hFFFFFFFE, -1);
        chk("d7_lo_c", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
        chk("d7_hi_c", 64'(bus.hi), 64'h0000_0000_0000_0001);
        do_op("dm7", 1'b1, 32'hFFFFFFF9, 32'd2, -1);
        chk("dm7_lo_c", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
        chk("dm7_hi_c", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
        do_op("dz5", 1'b1, 32'd5, 32'd0, -1);
        chk("dz5_lo_c", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
        do_op("dovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, -1);
        chk("dovf_lo_c", 64'(bus.lo), 64'h0000_0000_8000_0000);
        chk("dovf_hi_c", 64'(bus.hi), 64'd0);
`else
        do_op("dnone", 1'b1, 32'd9, 32'd3, -1);
        chk("dnone_hi_c", 64'(bus.hi), 64'h0000_0000_4000_0000);
        chk("dnone_lo_c", 64'(bus.lo), 64'd0);
`endif

        // Start pulse in the middle of a multiply must not disturb it.
        do_op("poke", 1'b0, 32'h12345678, 32'hFEDCBA98, 10);

        // Abort a multiply with reset at cycle 15.
        @(negedge clock);
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'h0BADF00D; bus.b = 32'h00C0FFEE;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (15) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("abort_hi",   64'(bus.hi),   64'd0);
        chk("abort_lo",   64'(bus.lo),   64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        mhi = '0; mlo = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (bus.done) done_seen++;
        end
        chk("abort_nodone", 64'(done_seen), 64'd0);
        do_op("m3x4", 1'b0, 32'd3, 32'd4, -1);
        chk("m3x4_lo_c", 64'(bus.lo), 64'd12);

        for (int i = 0; i < 24; i++) begin
            rop = 1'(($urandom_range(0, 2) == 0) ? 1 : 0) ^ 1'(i % 2);
            ra  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 300));
                default: rb = 32'($urandom);
            endcase
            do_op($sformatf("rnd%0d", i), rop, ra, rb, -1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter: DATA_W, default 32, operand/result width (verification at 32 only).
REQ-002 SHALL have port: clock  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  in  1  request strobe from control unit, sampled only in IDLE.
REQ-005 SHALL have port: op  in  1  0 = MULT, 1 = DIV; sampled with start.
REQ-006 SHALL have port: a  in  DATA_W  operand rs, signed; sampled with start.
REQ-007 SHALL have port: b  in  DATA_W  operand rt, signed; sampled with start.
REQ-008 SHALL have port: hi  out  DATA_W  HI register: product upper half, or remainder.
REQ-009 SHALL have port: lo  out  DATA_W  LO register: product lower half, or quotient.
REQ-010 SHALL have port: busy  out  1  high from accept edge until return to IDLE.
REQ-011 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-012 SHALL have port: div_zero  out  1  one-cycle pulse with done when DIV has b == 0.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; encodings from the package.
REQ-014 SHALL accept a request when start = 1 at a rising edge in IDLE (edge N): latch op/a/b, clear the iteration counter, enter CALC.
REQ-015 SHALL perform exactly DATA_W iterations in CALC, one per clock: MULT = radix-2 Booth step; DIV = restoring step on magnitudes.
REQ-016 SHALL enter DONE at edge N+DATA_W, update hi/lo on that edge, and drive done = 1 for that one cycle only.
REQ-017 SHALL return from DONE to IDLE on the next edge; busy = 1 from edge N up to that edge.
REQ-018 SHALL ignore start while busy = 1: no re-latch and no extension of the operation.
REQ-019 SHALL produce MULT results as the signed 2*DATA_W product: hi = bits [63:32], lo = bits [31:0].
REQ-020 SHALL produce DIV results with the quotient truncated toward zero in lo and the remainder, carrying the dividend's sign, in hi.
REQ-021 SHALL return lo = 0x80000000, hi = 0 for DIV 0x80000000 / 0xFFFFFFFF, with no flag.
REQ-022 SHALL, for DIV with b == 0, skip CALC: go IDLE -> DONE at edge N+1, leave hi/lo unchanged, and pulse div_zero with done.
REQ-023 SHALL hold hi/lo stable at all times except the DONE-entry edge.

Reset
REQ-024 SHALL, on reset assertion and independent of clock, force state = IDLE and hi = lo = 0, busy = done = div_zero = 0, and clear all internal registers.
REQ-025 SHALL, when reset is asserted mid-operation, abort the operation with no done pulse; the first start after deassertion is accepted normally.

Configuration
REQ-026 SHALL compile the divider under macro MULT_DIV_UNIT_DIVIDE_EN.
REQ-027 SHALL, with the macro defined, implement DIV per REQ-015 to REQ-022.
REQ-028 SHALL, without the macro, remove all divider datapath logic: DIV requests go IDLE -> DONE at edge N+1, pulse done, leave hi/lo unchanged, and keep div_zero = 0. MULT behaviour is unchanged.

Structure
REQ-029 SHALL place the following in shared package mult_div_pkg: op encodings (OP_MULT, OP_DIV), state typedef, DATA_W default, and iteration count.
REQ-030 SHALL place the combinational restoring-divide iteration in sub-module div_step, instantiated only under MULT_DIV_UNIT_DIVIDE_EN; the Booth step stays inline.

Verification
REQ-031 SHALL check: MULT a = 7, b = 0xFFFFFFFD -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB, done exactly 32 cycles after the accept edge, busy high 33 cycles.
REQ-032 SHALL check: MULT a = b = 0x80000000 -> hi = 0x40000000, lo = 0x00000000.
REQ-033 SHALL check: DIV a = 7, b = 0xFFFFFFFE -> lo = 0xFFFFFFFD, hi = 0x00000001; and DIV a = 0xFFFFFFF9, b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-034 SHALL check: DIV a = 5, b = 0 -> done and div_zero both high 1 cycle after accept, hi/lo keep prior values; and DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
REQ-035 SHALL check: start pulsed at cycle 10 of a MULT -> ignored and result unchanged; reset asserted at cycle 15 -> no done, hi = lo = 0, next MULT 3 * 4 -> lo = 12.
REQ-036 SHALL check: build without MULT_DIV_UNIT_DIVIDE_EN, DIV a = 9, b = 3 -> done at accept+1, div_zero = 0, hi/lo unchanged.
